// File: rtl/logdrop_window_stream_pkg.sv
// logdrop_window_stream_pkg: shared window constants, mode encodings
// and the floor-log2 helper used by the shift calculation.
package logdrop_window_stream_pkg;

  localparam int WINLEN_DEF = 32;
  localparam int W = $clog2(WINLEN_DEF);
  localparam int SHIFT_W = $clog2(W);

  localparam logic MODE_RECT = 1'b0;
  localparam logic MODE_LOGDROP = 1'b1;

  // floor(log2(a)); -1 for a == 0
  function automatic int flog2(input logic [31:0] a);
    int r;
    r = -1;
    for (int i = 0; i < 32; i++)
      if (a[i]) r = i;
    return r;
  endfunction

endpackage

// File: rtl/logdrop_window_stream_shift.sv
// logdrop_shift: window index + mode -> right-shift amount.
// Ports: t (index), mode (0=rect,1=logdrop), shift (amount).
module logdrop_shift
  import logdrop_window_stream_pkg::*;
#(
  parameter int IDX_W = 5,
  parameter int SH_W = 3
) (
  input  logic [IDX_W-1:0] t,
  input  logic             mode,
  output logic [SH_W-1:0]  shift
);

  logic [IDX_W-1:0] tm;
  logic [IDX_W-3:0] a;
  int               s;

  always_comb begin
    shift = '0;
    tm = t[IDX_W-1] ? ~t : t;
    a = tm[IDX_W-3:0];
    s = 0;
    // edge quarters only: distance from nearest edge sets the drop
    if (mode == MODE_LOGDROP && !(t[IDX_W-1] ^ t[IDX_W-2])) begin
      s = IDX_W - 2 - flog2(32'(a));
      shift = SH_W'(s);
    end
  end

endmodule

// File: rtl/logdrop_window_stream.sv
// logdrop_window_stream: streaming multi-channel logdrop/rect windower.
// Ports: i_clk/i_rst, i_cg gate, valid/ready in (i_x), out (o_y,o_t,o_last).
module logdrop_window_stream
  import logdrop_window_stream_pkg::*;
#(
  parameter int N_CHAN = 2,
  parameter int DATA_W = 8,
  parameter int WINLEN = 32
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_cg,
  input  logic                       i_mode,
  input  logic                       i_restart,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [N_CHAN*DATA_W-1:0]   i_x,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [N_CHAN*DATA_W-1:0]   o_y,
  output logic [$clog2(WINLEN)-1:0]  o_t,
  output logic                       o_last
);

  localparam int TW = $clog2(WINLEN);
  localparam int TSW = $clog2(TW);
  localparam logic [TW-1:0] T_LAST = TW'(WINLEN - 1);

  logic [TW-1:0]            t_q;
  logic                     mode_q;
  logic [TW-1:0]            t_use;
  logic                     mode_use;
  logic                     accept;
  logic                     transfer;
  logic [TSW-1:0]           shift;
  logic [N_CHAN*DATA_W-1:0] y;

  assign o_ready = i_cg && (!o_valid || i_ready);
  assign accept = i_valid && o_ready;
  assign transfer = i_cg && o_valid && i_ready;

  assign t_use = i_restart ? '0 : t_q;
  // a window start picks up the live mode for its own first sample
  assign mode_use = (t_use == '0) ? i_mode : mode_q;

  logdrop_shift #(
    .IDX_W (TW),
    .SH_W  (TSW)
  ) u_shift (
    .t     (t_use),
    .mode  (mode_use),
    .shift (shift)
  );

  for (genvar c = 0; c < N_CHAN; c++) begin : g_ch
    assign y[c*DATA_W +: DATA_W] = i_x[c*DATA_W +: DATA_W] >> shift;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      t_q     <= '0;
      mode_q  <= MODE_LOGDROP;
      o_valid <= 1'b0;
      o_y     <= '0;
      o_t     <= '0;
      o_last  <= 1'b0;
    end else if (i_cg) begin
      if (accept) begin
        t_q     <= t_use + 1'b1;
        o_valid <= 1'b1;
        o_y     <= y;
        o_t     <= t_use;
        o_last  <= (t_use == T_LAST);
        if (t_use == '0) mode_q <= i_mode;
      end else begin
        if (i_restart) t_q <= '0;
        if (transfer) o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_logdrop_window_stream.sv
// tb_logdrop_window_stream: directed checks of window shape, mode
// latching, backpressure, restart, reset and clock gating (WINLEN=16).
module tb_logdrop_window_stream;

  localparam int N_CHAN = 2;
  localparam int DATA_W = 8;
  localparam int WINLEN = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cg = 1'b1;
  logic        mode = 1'b1;
  logic        restart = 1'b0;
  logic        vin = 1'b0;
  logic        rdy_dn = 1'b1;
  logic [15:0] x = '0;
  logic        o_ready;
  logic        o_valid;
  logic [15:0] o_y;
  logic [3:0]  o_t;
  logic        o_last;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] ld_tab [16] = '{8'h1F, 8'h3F, 8'h7F, 8'h7F,
                              8'hFF, 8'hFF, 8'hFF, 8'hFF,
                              8'hFF, 8'hFF, 8'hFF, 8'hFF,
                              8'h7F, 8'h7F, 8'h3F, 8'h1F};
  int sh_tab [16] = '{3, 2, 1, 1, 0, 0, 0, 0,
                      0, 0, 0, 0, 1, 1, 2, 3};
  logic [7:0] a5 = 8'hA5;

  logdrop_window_stream #(
    .N_CHAN (N_CHAN),
    .DATA_W (DATA_W),
    .WINLEN (WINLEN)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_cg      (cg),
    .i_mode    (mode),
    .i_restart (restart),
    .i_valid   (vin),
    .o_ready   (o_ready),
    .i_x       (x),
    .o_valid   (o_valid),
    .i_ready   (rdy_dn),
    .o_y       (o_y),
    .o_t       (o_t),
    .o_last    (o_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] x1, input logic [7:0] x0,
                      input logic m, input logic rs);
    x = {x1, x0};
    mode = m;
    restart = rs;
    vin = 1'b1;
    @(posedge clk);
    #1;
    vin = 1'b0;
    restart = 1'b0;
  endtask

  task automatic exp_out(input string tag, input logic [7:0] y1,
                         input logic [7:0] y0, input int t,
                         input logic last);
    chk({tag, "_v"}, 32'(o_valid), 32'd1);
    chk({tag, "_y0"}, 32'(o_y[7:0]), 32'(y0));
    chk({tag, "_y1"}, 32'(o_y[15:8]), 32'(y1));
    chk({tag, "_t"}, 32'(o_t), 32'(t));
    chk({tag, "_last"}, 32'(o_last), 32'(last));
  endtask

  initial begin
    #1;
    chk("rst_v", 32'(o_valid), 32'd0);
    chk("rst_y", 32'(o_y), 32'd0);
    chk("rst_t", 32'(o_t), 32'd0);
    chk("rst_last", 32'(o_last), 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    chk("rst_rdy", 32'(o_ready), 32'd1);

    // logdrop sweep, ch1 carries a non-saturated pattern
    for (int i = 0; i < 16; i++) begin
      send(8'hA5, 8'hFF, 1'b1, 1'b0);
      exp_out("ld", a5 >> sh_tab[i], ld_tab[i], i, i == 15);
    end

    // rect window; mid-window mode flip is ignored
    for (int i = 0; i < 16; i++) begin
      send(8'hFF, 8'hFF, (i < 5) ? 1'b0 : 1'b1, 1'b0);
      exp_out("rect", 8'hFF, 8'hFF, i, i == 15);
    end
    send(8'hFF, 8'hFF, 1'b1, 1'b0);
    exp_out("mnext0", 8'h1F, 8'h1F, 0, 1'b0);
    send(8'hFF, 8'hFF, 1'b1, 1'b0);
    exp_out("mnext1", 8'h3F, 8'h3F, 1, 1'b0);

    // backpressure
    send(8'hFF, 8'hFF, 1'b1, 1'b0);
    exp_out("bp2", 8'h7F, 8'h7F, 2, 1'b0);
    rdy_dn = 1'b0;
    x = 16'hFFFF;
    vin = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("bp_rdy", 32'(o_ready), 32'd0);
      exp_out("bp_hold", 8'h7F, 8'h7F, 2, 1'b0);
    end
    rdy_dn = 1'b1;
    @(posedge clk);
    #1;
    vin = 1'b0;
    exp_out("bp3", 8'h7F, 8'h7F, 3, 1'b0);
    send(8'hFF, 8'hFF, 1'b1, 1'b0);
    exp_out("bp4", 8'hFF, 8'hFF, 4, 1'b0);

    // restart with and without accept
    for (int i = 5; i < 9; i++) send(8'hFF, 8'hFF, 1'b1, 1'b0);
    chk("pre_rs_t", 32'(o_t), 32'd8);
    send(8'hFF, 8'hFF, 1'b1, 1'b1);
    exp_out("rs0", 8'h1F, 8'h1F, 0, 1'b0);
    send(8'hFF, 8'hFF, 1'b1, 1'b0);
    exp_out("rs1", 8'h3F, 8'h3F, 1, 1'b0);
    rdy_dn = 1'b0;
    restart = 1'b1;
    @(posedge clk);
    #1;
    restart = 1'b0;
    exp_out("rs_hold", 8'h3F, 8'h3F, 1, 1'b0);
    rdy_dn = 1'b1;
    @(posedge clk);
    #1;
    chk("drain_v", 32'(o_valid), 32'd0);
    send(8'hFF, 8'hFF, 1'b1, 1'b0);
    exp_out("rs_na0", 8'h1F, 8'h1F, 0, 1'b0);

    // async reset mid-window
    for (int i = 1; i < 7; i++) send(8'hFF, 8'hFF, 1'b1, 1'b0);
    send(8'hFF, 8'hFF, 1'b1, 1'b0);
    exp_out("pre_rst7", 8'hFF, 8'hFF, 7, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_v", 32'(o_valid), 32'd0);
    chk("ar_t", 32'(o_t), 32'd0);
    chk("ar_y", 32'(o_y), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(8'hFF, 8'hFF, 1'b1, 1'b0);
    exp_out("post_rst0", 8'h1F, 8'h1F, 0, 1'b0);

    // clock gate
    send(8'hFF, 8'hFF, 1'b1, 1'b0);
    exp_out("cg_pre", 8'h3F, 8'h3F, 1, 1'b0);
    cg = 1'b0;
    vin = 1'b1;
    restart = 1'b1;
    x = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("cg_rdy", 32'(o_ready), 32'd0);
      exp_out("cg_hold", 8'h3F, 8'h3F, 1, 1'b0);
    end
    cg = 1'b1;
    vin = 1'b0;
    restart = 1'b0;
    send(8'hFF, 8'hFF, 1'b1, 1'b0);
    exp_out("cg_resume", 8'h7F, 8'h7F, 2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
